// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Generic elastic pipeline stage with a WIDTH-bit payload. The stage uses a
// valid/ready handshake and holds up to two entries: a main register and a
// skid register. in_ready depends only on registered state, so out_ready has
// no combinational path to in_ready, and stalls do not ripple back through
// the pipeline in the same cycle. All state changes on the falling edge of
// clock, which matches the rest of the pipeline.
//
// Parameters
//   WIDTH   payload width in bits
//   BUBBLE  payload loaded on reset/flush and shown on out_data when empty
//
// Ports
//   clock         stage clock (state updates on falling edge)
//   reset         synchronous active-high reset, highest priority
//   flush         synchronous discard of all held entries
//   in_valid      upstream offers in_data
//   in_ready      stage can accept (registered-state only)
//   in_data       upstream payload
//   out_valid     out_data holds a valid entry
//   out_ready     downstream accepts out_data this cycle
//   out_data      head entry, or BUBBLE when empty
//   occupancy     number of held entries, 0..2
//   stall_cycles  count of cycles with out_valid=1 and out_ready=0
//
// Build option
//   PIPE_STAGE_STALL_COUNT_EN  when defined, stall_cycles is a saturating
//                              counter that only reset clears; otherwise it
//                              is tied to zero. The port list is the same in
//                              both builds.
//
// FSM state (count_q)
//   state | meaning
//   0     | empty, main register = BUBBLE
//   1     | main register holds the head entry
//   2     | main holds the head entry, skid holds the next one
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
   parameter int               WIDTH  = 290,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [31:0]      stall_cycles
);

   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic [1:0]       count_q;
   logic             push;
   logic             pop;

   assign out_valid = (count_q != 2'd0);
   assign in_ready  = (count_q != 2'd2);
   assign out_data  = main_q;
   assign occupancy = count_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_ff @(negedge clock) begin
      if (reset || flush) begin
         // A pop in this cycle has already been consumed downstream, and a
         // push is dropped, so clearing everything covers both cases.
         count_q <= 2'd0;
         main_q  <= BUBBLE;
         skid_q  <= BUBBLE;
      end else begin
         case (count_q)
            2'd0: begin
               if (push) begin
                  main_q  <= in_data;
                  count_q <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  main_q <= in_data;
               end else if (push) begin
                  skid_q  <= in_data;
                  count_q <= 2'd2;
               end else if (pop) begin
                  main_q  <= BUBBLE;
                  count_q <= 2'd0;
               end
            end
            2'd2: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  main_q  <= skid_q;
                  skid_q  <= BUBBLE;
                  count_q <= 2'd1;
               end
            end
            default: begin
               // Unreachable encoding; fall back to empty.
               count_q <= 2'd0;
               main_q  <= BUBBLE;
               skid_q  <= BUBBLE;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_STALL_COUNT_EN
   logic [31:0] stall_q;

   // Flush does not clear the counter; only reset does.
   always_ff @(negedge clock) begin
      if (reset) begin
         stall_q <= 32'h0;
      end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Directed bench for pipe_stage_elastic with WIDTH=8, BUBBLE=8'hA5. A table
// of per-edge vectors covers reset, streaming, backpressure and flush.
// Hand-written sequences then cover reset during a transfer and the stall
// counter. Inputs change one time unit after the falling edge, and outputs
// are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

   localparam int         W   = 8;
   localparam logic [7:0] BUB = 8'hA5;
`ifdef PIPE_STAGE_STALL_COUNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;
   logic [31:0]  stall_cycles;

   int total = 0;
   int bad   = 0;

   pipe_stage_elastic #(.WIDTH(W), .BUBBLE(BUB)) dut (
      .clock(clock),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .occupancy(occupancy),
      .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic       fl;
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       e_ov;
      logic       e_ir;
      logic [7:0] e_od;
      logic [1:0] e_occ;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic fl, input logic iv,
                      input logic [7:0] id, input logic ordy,
                      input logic e_ov, input logic e_ir,
                      input logic [7:0] e_od, input logic [1:0] e_occ);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od; v.e_occ = e_occ;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic iv,
                        input logic [7:0] id, input logic ordy);
      reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
      @(negedge clock);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic e_ov,
                             input logic e_ir, input logic [7:0] e_od,
                             input logic [1:0] e_occ);
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
      check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
      check({tag, ".out_data"},  {24'd0, out_data},  {24'd0, e_od});
      check({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, e_occ});
   endtask

   initial begin
      // reset and idle
      add(1, 0, 0, 8'h00, 0, 0, 1, BUB, 0);
      add(0, 0, 0, 8'h00, 0, 0, 1, BUB, 0);
      // streaming 01..10 with out_ready high: each value appears one edge later
      for (int i = 1; i <= 16; i++)
         add(0, 0, 1, 8'(i), 1, 1, 1, 8'(i), 1);
      add(0, 0, 0, 8'h00, 1, 0, 1, BUB, 0);
      // backpressure: 11, 22 held; 33 refused while full
      add(0, 0, 1, 8'h11, 0, 1, 1, 8'h11, 1);
      add(0, 0, 1, 8'h22, 0, 1, 0, 8'h11, 2);
      add(0, 0, 1, 8'h33, 0, 1, 0, 8'h11, 2);
      add(0, 0, 1, 8'h33, 1, 1, 1, 8'h22, 1);
      add(0, 0, 1, 8'h33, 1, 1, 1, 8'h33, 1);
      add(0, 0, 0, 8'h00, 1, 0, 1, BUB, 0);
      // flush while full, with a same-edge push of 44 that must be dropped
      add(0, 0, 1, 8'h11, 0, 1, 1, 8'h11, 1);
      add(0, 0, 1, 8'h22, 0, 1, 0, 8'h11, 2);
      add(0, 1, 1, 8'h44, 0, 0, 1, BUB, 0);
      add(0, 0, 0, 8'h00, 1, 0, 1, BUB, 0);
      add(0, 0, 0, 8'h00, 1, 0, 1, BUB, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         check_outs($sformatf("row%0d", i), vecs[i].e_ov, vecs[i].e_ir,
                    vecs[i].e_od, vecs[i].e_occ);
      end

      // reset during a transfer, with flush and push on the same edge
      drive(0, 0, 1, 8'h11, 0);
      drive(0, 0, 1, 8'h22, 0);
      check_outs("full_before_reset", 1, 0, 8'h11, 2);
      drive(1, 1, 1, 8'h66, 0);
      check_outs("mid_reset", 0, 1, BUB, 0);
      check("mid_reset.stall_cycles", stall_cycles, 32'h0);
      drive(0, 0, 1, 8'h55, 0);
      check_outs("push55", 1, 1, 8'h55, 1);
      check("push55.stall_cycles", stall_cycles, 32'h0);

      // seven stall edges
      for (int i = 0; i < 7; i++) drive(0, 0, 0, 8'h00, 0);
      check("stall7", stall_cycles, STALL_EN ? 32'd7 : 32'd0);
      check_outs("stall7_hold", 1, 1, 8'h55, 1);
      // flush with out_ready high is a delivery, not a stall; counter unchanged
      drive(0, 1, 0, 8'h00, 1);
      check_outs("flush_keep", 0, 1, BUB, 0);
      check("flush_keep.stall_cycles", stall_cycles, STALL_EN ? 32'd7 : 32'd0);

`ifdef PIPE_STAGE_STALL_COUNT_EN
      force dut.stall_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_q;
      #1;
`endif
      drive(0, 0, 1, 8'h77, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, 0);
      check("stall_saturate", stall_cycles, STALL_EN ? 32'hFFFF_FFFF : 32'd0);
      check_outs("sat_hold", 1, 1, 8'h77, 1);

      drive(1, 0, 0, 8'h00, 0);
      check("final_reset.stall_cycles", stall_cycles, 32'h0);
      check_outs("final_reset", 0, 1, BUB, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor of the fixed-width inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- A single generic stage of WIDTH bits with a valid/ready handshake, a 2-entry skid buffer, and synchronous flush-to-bubble.
- Lets the EX stage stall on multi-cycle ops (mult/div, MFHI/MFLO) without combinational ready paths crossing stages.
- Instantiated between any two pipeline stages; the caller concatenates its control/data fields into in_data.

Parameters:
- WIDTH, 290, bits per stage payload.
- BUBBLE, {WIDTH{1'b0}}, payload loaded on reset/flush and driven on out_data when empty (NOP encoding chosen per instance).

Ports:
- clock  input  1  stage clock; all state updates on falling edge, matching the rest of the pipeline.
- reset  input  1  synchronous, active-high; sampled on falling edge of clock.
- flush  input  1  synchronous discard of all held entries (branch/exception redirect).
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept; function of registered state only.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  head entry, or BUBBLE when empty.
- occupancy  output  2  entries held, 0..2.
- stall_cycles  output  32  backpressure counter (see Optional Feature).

Behaviour:
- State: main register M (drives out_data), skid register S, count (0..2). occupancy = count.
- Combinational outputs: out_valid = (count != 0); in_ready = (count != 2); out_data = M.
- Handshakes, evaluated at the falling edge: push = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions when not reset/flush:
  - count0: push -> M=in_data, count=1; else hold.
  - count1: push&pop -> M=in_data, count=1; push only -> S=in_data, count=2; pop only -> M=BUBBLE, count=0; neither -> hold.
  - count2: pop -> M=S, S=BUBBLE, count=1; else hold. push is impossible (in_ready=0).
- Latency: data pushed at edge k is on out_data after edge k (one stage).
- Throughput: 1 entry per cycle while out_ready=1. No combinational path from out_ready to in_ready.
- Ordering: strict FIFO; no entry is duplicated or dropped except by flush/reset.
- in_valid with in_ready=0: no state change. Upstream must hold in_data stable until accepted.
- Flush:
  - Next state is count=0, M=S=BUBBLE.
  - A push in the same cycle is discarded.
  - A pop in the same cycle counts as delivered (the downstream has already consumed it).
  - in_ready after a flush edge is 1.
- Reset: highest priority, above flush.
  - Next state is count=0, M=S=BUBBLE, stall_cycles=0.
  - After the reset edge: out_valid=0, in_ready=1, out_data=BUBBLE, occupancy=0.
  - Reset mid-transfer discards all entries, including a push in the same cycle.
- S is don't-care when count<2 but is kept at BUBBLE for waveform clarity.

Optional Feature:
- Macro: PIPE_STAGE_STALL_COUNT_EN.
- Defined: stall_cycles increments at each falling edge where out_valid=1 and out_ready=0 and reset=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset; flush does not clear it.
- Undefined: stall_cycles tied to 32'h0 and no counter logic is synthesised. Port list is identical in both builds.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, occupancy=0, out_data=BUBBLE (WIDTH=8, BUBBLE=8'hA5 -> 8'hA5).
- Streaming: out_ready=1, push 8'h01..8'h10 on consecutive edges -> out_data shows 01..10 one edge later each, occupancy stays 1, no gaps.
- Backpressure: out_ready=0, push 8'h11, 8'h22, then offer 8'h33.
  - Expect occupancy=2, in_ready=0; 33 not accepted.
  - Raise out_ready: pops 11, 22, then 33 after re-offer; order preserved.
- Flush with full buffer (11, 22 held), flush=1 and in_valid=1 with 8'h44 on the same edge -> occupancy=0, out_data=A5, 44 never emerges.
- Reset mid-operation: count=2 with 11, 22 held, assert reset together with flush and push -> all cleared, stall_cycles=0, next push 8'h55 appears after one edge.
- PIPE_STAGE_STALL_COUNT_EN defined: hold out_valid=1, out_ready=0 for 7 edges -> stall_cycles=7.
  - Flush does not change it.
  - Force 32'hFFFF_FFFE plus 3 stall edges -> 32'hFFFF_FFFF.
  - Undefined build: stall_cycles stays 0.
